mux4_rr_arbiter: RTL
====================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares a 4:1 one-bit selection datapath between four requesters.
- Grants one requester at a time, drives the 2-bit mux select (sel[1] = s1, sel[0] = s0) and presents the selected bit downstream with a valid/ready handshake.
- Limits each grant's tenure to HOLD_MAX accepted transfers for fairness.
- Sits between the four source lanes and a single downstream consumer.

Parameters:
- HOLD_MAX, 4, maximum accepted transfers per grant; legal range 1..255.
- CNT_W, 8, width of the tenure counter; must hold HOLD_MAX.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  4  per-requester request; bit k means lane k has data.
- din  input  4  per-requester data bit; din[k] is lane k (i0..i3).
- out_ready  input  1  downstream accepts out_data this cycle.
- out_valid  output  1  out_data is valid.
- out_data  output  1  selected lane bit, equal to din[sel].
- gnt  output  4  one-hot grant, registered.
- sel  output  2  registered mux select; sel = index of the granted lane.
- busy  output  1  high in GRANT state.

Behaviour:
- Clock and reset
  - One clock domain.
  - Reset is synchronous and active-high.
  - Reset values: state = IDLE, gnt = 4'b0000, sel = 2'b00, busy = 0, out_valid = 0, tenure counter = 0, priority pointer ptr = 0.
  - rst asserted in any state, including mid-grant, returns everything to reset values on that edge. Any in-flight transfer is dropped and no release is recorded.
- States
  - IDLE:
    - If req == 0, stay in IDLE.
    - Otherwise pick the first k with req[k] = 1, scanning ptr, ptr+1, ... (mod 4).
    - Next edge: gnt = one-hot(k), sel = k, counter = 0, state = GRANT.
    - Latency from req assertion to gnt is 1 cycle.
  - GRANT:
    - out_valid = req[sel] (combinational from the registered sel).
    - out_data = din[sel]. The mux is pure combinational, so din changes propagate in the same cycle.
    - A transfer occurs when out_valid & out_ready; each transfer increments the counter.
- Release (evaluated each cycle in GRANT)
  - Release happens when req[sel] = 0, or when a transfer occurs with counter == HOLD_MAX-1.
  - On release, at the next edge: gnt = 0, state = IDLE, ptr = (sel+1) mod 4. sel keeps its value.
  - Exactly one idle cycle separates consecutive grants.
- Stall
  - out_ready = 0 holds state, counter and sel. Tenure does not expire while stalled.
- Simultaneous events
  - If req[sel] drops in the same cycle as out_ready = 1: no transfer is counted (out_valid = 0), and the grant is released.
- Fairness
  - A requester that holds req continuously waits at most 3 grants of at most HOLD_MAX transfers each.
- Wrap-around
  - ptr wraps from 3 to 0.
  - The counter never exceeds HOLD_MAX-1.
  - With HOLD_MAX = 1, every accepted transfer releases the grant.
- Invariants
  - gnt is always zero or one-hot.
  - gnt != 0 exactly when busy = 1.
  - out_valid is never 1 in IDLE.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, GRANT);
  - constant N_REQ = 4;
  - the select width SEL_W = 2.
- One natural sub-module: mux4_sel, a purely combinational 4:1 one-bit selector driven by sel. It is instantiated once for out_data.
- The round-robin pick (rotate, priority-encode, rotate back) stays inline as a function.

Test Plan:
1. Reset with req = 4'b1111 held, then release reset → gnt = 0001 and sel = 0 one cycle after reset deasserts; out_valid = 1; out_data = din[0].
2. req = 4'b1111, out_ready = 1, HOLD_MAX = 4 → grant order 0,1,2,3,0. Each grant carries exactly 4 transfers, and there is 1 idle cycle between grants.
3. Grant on lane 2 with out_ready = 0 for 10 cycles → sel stays 2, the counter stays 0 and no release occurs. Then out_ready = 1 → 4 transfers followed by release.
4. Grant on lane 1, drop req[1] after 2 transfers → out_valid = 0 that cycle, release on the next edge, ptr = 2. With req = 4'b1001 the next grant goes to lane 3.
5. Toggle din[sel] every cycle during a grant → out_data follows in the same cycle; non-granted din bits have no effect.
6. Assert rst mid-grant (lane 3, counter = 2) → next edge: gnt = 0, sel = 0, out_valid = 0, ptr = 0. With req = 4'b1010 the next grant goes to lane 1.

Source files
------------

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and sizes for the 4-lane round-robin selection arbiter.
package mux4_rr_arbiter_pkg;
  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;
endpackage

// File: rtl/mux4_sel.sv
// Combinational 4:1 one-bit selector; lane bit chosen by the registered select.
module mux4_sel
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] i_din,
  input  logic [SEL_W-1:0] i_sel,
  output logic             o_y
);
  assign o_y = i_din[i_sel];
endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter over four lanes with a tenure limit per grant and a
// valid/ready output carrying the granted lane's data bit.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] din,
  input  logic             out_ready,
  output logic             out_valid,
  output logic             out_data,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy
);

  // Rotate so ptr sits at bit 0, take the lowest set bit, rotate the index back.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [SEL_W-1:0] p);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [SEL_W-1:0]   idx;
    dbl = {r, r};
    rot = N_REQ'(dbl >> p);
    idx = '0;
    for (int i = N_REQ-1; i >= 0; i--)
      if (rot[i]) idx = SEL_W'(i);
    return idx + p;
  endfunction

  state_t           r_state;
  logic [N_REQ-1:0] r_gnt;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;

  logic [SEL_W-1:0] w_pick;
  logic             w_xfer;
  logic             w_last;
  logic             w_release;

  assign w_pick    = rr_pick(req, r_ptr);
  assign out_valid = (r_state == ST_GRANT) & req[r_sel];
  assign w_xfer    = out_valid & out_ready;
  assign w_last    = (r_cnt == CNT_W'(HOLD_MAX - 1));
  // A dropped request releases without counting; stalls never expire tenure.
  assign w_release = (r_state == ST_GRANT) & (~req[r_sel] | (w_xfer & w_last));

  assign gnt  = r_gnt;
  assign sel  = r_sel;
  assign busy = (r_state == ST_GRANT);

  mux4_sel u_mux (
    .i_din (din),
    .i_sel (r_sel),
    .o_y   (out_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_state <= ST_GRANT;
            r_gnt   <= N_REQ'(1) << w_pick;
            r_sel   <= w_pick;
            r_cnt   <= '0;
          end
        end
        ST_GRANT: begin
          if (w_release) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_ptr   <= r_sel + SEL_W'(1);
            r_cnt   <= '0;
          end else if (w_xfer) begin
            r_cnt   <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

endmodule
